// File: rtl/vga_axi_pkg.sv
// rtl/vga_axi_pkg.sv - shared types and constants for the VGA framebuffer fetch master
package vga_axi_pkg;

  typedef enum logic [1:0] {
    RESET,
    IDLE,
    ADDR,
    DATA
  } mem_ctrl_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] ARPROT_DEFAULT = 3'b001;

endpackage

// File: rtl/vga_fb_addr_gen.sv
// rtl/vga_fb_addr_gen.sv - decodes pixel/line counters into active/boundary flags and the next-word byte address
module vga_fb_addr_gen #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        PXL_CTR_WIDTH  = 10,
  parameter int                        LINE_CTR_WIDTH = 10,
  parameter int                        PXL_WIDTH      = 16,
  parameter int                        H_ACTIVE       = 640,
  parameter int                        V_ACTIVE       = 480,
  parameter logic [AXI_ADDR_WIDTH-1:0] FB_BASE_ADDR   = '0
) (
  input  logic [PXL_CTR_WIDTH-1:0]  pxl_i,
  input  logic [LINE_CTR_WIDTH-1:0] line_i,
  output logic                      active_o,
  output logic                      boundary_o,
  output logic [31:0]               slot_o,
  output logic [AXI_ADDR_WIDTH-1:0] tgt_addr_o
);

  localparam int PPW            = AXI_DATA_WIDTH / PXL_WIDTH;
  localparam int BYTES_PER_WORD = AXI_DATA_WIDTH / 8;

  logic [31:0] pxl;
  logic [31:0] line;
  logic [31:0] tgt_pxl;
  logic [31:0] tgt_line;
  logic [31:0] word;

  // 32-bit arithmetic comfortably covers V_ACTIVE*H_ACTIVE pixel indices
  always_comb begin
    pxl      = 32'(pxl_i);
    line     = 32'(line_i);
    tgt_pxl  = '0;
    tgt_line = '0;
    if (pxl + PPW < H_ACTIVE) begin
      tgt_pxl  = pxl + PPW;
      tgt_line = line;
    end else if (line + 1 < V_ACTIVE) begin
      tgt_line = line + 1;
    end
    word       = (tgt_line * H_ACTIVE + tgt_pxl) / PPW;
    tgt_addr_o = FB_BASE_ADDR + AXI_ADDR_WIDTH'(word * BYTES_PER_WORD);
    active_o   = (pxl < H_ACTIVE) && (line < V_ACTIVE);
    slot_o     = pxl % PPW;
    boundary_o = (slot_o == 32'd0);
  end

endmodule

// File: rtl/vga_axi_mem_ctrl.sv
// rtl/vga_axi_mem_ctrl.sv - AXI4-Lite read master prefetching framebuffer words one ahead of the display
module vga_axi_mem_ctrl
  import vga_axi_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        PXL_CTR_WIDTH  = 10,
  parameter int                        LINE_CTR_WIDTH = 10,
  parameter int                        PXL_WIDTH      = 16,
  parameter int                        H_ACTIVE       = 640,
  parameter int                        V_ACTIVE       = 480,
  parameter logic [AXI_ADDR_WIDTH-1:0] FB_BASE_ADDR   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PXL_CTR_WIDTH-1:0]  pxl_ctr_i,
  input  logic [LINE_CTR_WIDTH-1:0] line_ctr_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [2:0]                m_arprot_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arrdy_i,
  input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rrdy_o,
  input  logic [1:0]                m_rresp_i,
  output logic [PXL_WIDTH-1:0]      pxl_data_o,
  output logic                      underrun_o,
  output logic                      rd_err_o
);

  mem_ctrl_state_t state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [AXI_DATA_WIDTH-1:0] pending_q, pending_d;
  logic [AXI_DATA_WIDTH-1:0] display_q, display_d;
  logic [PXL_WIDTH-1:0]      pxl_data_q, pxl_data_d;
  logic                      underrun_q, underrun_d;
  logic                      rd_err_q, rd_err_d;
  logic [PXL_CTR_WIDTH-1:0]  prev_pxl_q;

  logic                      active;
  logic                      boundary;
  logic [31:0]               slot;
  logic [AXI_ADDR_WIDTH-1:0] tgt_addr;
  logic                      ctr_change;
  logic                      trigger;
  logic                      arvalid;
  logic                      rrdy;

  vga_fb_addr_gen #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
    .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
    .PXL_CTR_WIDTH  (PXL_CTR_WIDTH),
    .LINE_CTR_WIDTH (LINE_CTR_WIDTH),
    .PXL_WIDTH      (PXL_WIDTH),
    .H_ACTIVE       (H_ACTIVE),
    .V_ACTIVE       (V_ACTIVE),
    .FB_BASE_ADDR   (FB_BASE_ADDR)
  ) u_addr_gen (
    .pxl_i      (pxl_ctr_i),
    .line_i     (line_ctr_i),
    .active_o   (active),
    .boundary_o (boundary),
    .slot_o     (slot),
    .tgt_addr_o (tgt_addr)
  );

  assign ctr_change = (pxl_ctr_i != prev_pxl_q);
  assign trigger    = ctr_change && active && boundary;

  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    pending_d  = pending_q;
    display_d  = display_q;
    pxl_data_d = pxl_data_q;
    underrun_d = 1'b0;
    rd_err_d   = 1'b0;
    arvalid    = 1'b0;
    rrdy       = 1'b0;

    case (state_q)
      RESET: begin
        araddr_d = FB_BASE_ADDR;
        state_d  = ADDR;
      end
      IDLE: begin
        if (trigger) begin
          araddr_d = tgt_addr;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (m_arrdy_i) state_d = DATA;
      end
      DATA: begin
        rrdy = 1'b1;
        if (m_rvalid_i) begin
          pending_d = (m_rresp_i == AXI_RESP_OKAY) ? m_rdata_i : '0;
          rd_err_d  = (m_rresp_i != AXI_RESP_OKAY);
          state_d   = IDLE;
        end
      end
      default: state_d = RESET;
    endcase

    // A boundary that arrives while a fetch is still busy is dropped, not queued
    if (trigger) begin
      display_d  = pending_q;
      underrun_d = (state_q != IDLE);
    end

    if (ctr_change) begin
      if (trigger)     pxl_data_d = pending_q[PXL_WIDTH-1:0];
      else if (active) pxl_data_d = PXL_WIDTH'(display_q >> (slot * PXL_WIDTH));
      else             pxl_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RESET;
      araddr_q   <= FB_BASE_ADDR;
      pending_q  <= '0;
      display_q  <= '0;
      pxl_data_q <= '0;
      underrun_q <= 1'b0;
      rd_err_q   <= 1'b0;
      prev_pxl_q <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      pending_q  <= pending_d;
      display_q  <= display_d;
      pxl_data_q <= pxl_data_d;
      underrun_q <= underrun_d;
      rd_err_q   <= rd_err_d;
      prev_pxl_q <= pxl_ctr_i;
    end
  end

  assign m_araddr_o  = araddr_q;
  assign m_arprot_o  = ARPROT_DEFAULT;
  assign m_arvalid_o = arvalid;
  assign m_rrdy_o    = rrdy;
  assign pxl_data_o  = pxl_data_q;
  assign underrun_o  = underrun_q;
  assign rd_err_o    = rd_err_q;

endmodule

// File: tb/tb_vga_axi_mem_ctrl.sv
// tb/tb_vga_axi_mem_ctrl.sv - directed self-checking bench for vga_axi_mem_ctrl
module tb_vga_axi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pxl_ctr = 10'd700;
  logic [9:0]  line_ctr = 10'd0;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arrdy = 1'b0;
  logic [63:0] rdata = '0;
  logic        rvalid = 1'b0;
  logic        rrdy;
  logic [1:0]  rresp = 2'b00;
  logic [15:0] pxl_data;
  logic        underrun;
  logic        rd_err;

  int total = 0;
  int bad = 0;
  int ar_hs = 0;
  int r_hs = 0;

  vga_axi_mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pxl_ctr_i   (pxl_ctr),
    .line_ctr_i  (line_ctr),
    .m_araddr_o  (araddr),
    .m_arprot_o  (arprot),
    .m_arvalid_o (arvalid),
    .m_arrdy_i   (arrdy),
    .m_rdata_i   (rdata),
    .m_rvalid_i  (rvalid),
    .m_rrdy_o    (rrdy),
    .m_rresp_i   (rresp),
    .pxl_data_o  (pxl_data),
    .underrun_o  (underrun),
    .rd_err_o    (rd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arrdy) ar_hs++;
    if (rvalid && rrdy) r_hs++;
  end

  task automatic step(input int p, input int l);
    pxl_ctr  = 10'(p);
    line_ctr = 10'(l);
    @(negedge clk);
  endtask

  task automatic serve_ar(input int wait_cycles, output logic [31:0] addr, output bit stable, output bit ok);
    int n = 0;
    ok = 1'b0;
    stable = 1'b1;
    addr = '0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arvalid) return;
    addr = araddr;
    repeat (wait_cycles) begin
      @(negedge clk);
      if (!arvalid || araddr !== addr) stable = 1'b0;
    end
    arrdy = 1'b1;
    @(negedge clk);
    arrdy = 1'b0;
    ok = 1'b1;
  endtask

  task automatic serve_r(input logic [63:0] d, input logic [1:0] resp, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!rrdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rrdy) return;
    rvalid = 1'b1;
    rdata  = d;
    rresp  = resp;
    @(negedge clk);
    rvalid = 1'b0;
    rresp  = 2'b00;
    ok = 1'b1;
  endtask

  task automatic fetch(input int ar_wait, input logic [63:0] d, input logic [1:0] resp,
                       output logic [31:0] addr, output bit stable, output bit ok);
    bit ok_ar, ok_r;
    serve_ar(ar_wait, addr, stable, ok_ar);
    ok_r = 1'b0;
    if (ok_ar) serve_r(d, resp, ok_r);
    ok = ok_ar && ok_r;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b want=0", arvalid); end
    total++; if (rrdy !== 1'b0) begin bad++; $display("FAIL rst_rrdy got=%b want=0", rrdy); end
    total++; if (araddr !== 32'h0) begin bad++; $display("FAIL rst_araddr got=%h want=0", araddr); end
    total++; if (arprot !== 3'b001) begin bad++; $display("FAIL rst_arprot got=%b want=001", arprot); end
    total++; if (pxl_data !== 16'h0) begin bad++; $display("FAIL rst_pxl got=%h want=0", pxl_data); end
    total++; if (underrun !== 1'b0 || rd_err !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b want=00", underrun, rd_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    logic [31:0] a; bit st, ok;
    fetch(0, 64'h0004_0003_0002_0001, 2'b00, a, st, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_ok got=0 want=1"); end
    total++; if (a !== 32'h0) begin bad++; $display("FAIL first_addr got=%h want=0", a); end
    total++; if (ar_hs !== 1 || r_hs !== 1) begin bad++; $display("FAIL first_hs got=%0d/%0d want=1/1", ar_hs, r_hs); end
    total++; if (arvalid !== 1'b0 || rrdy !== 1'b0) begin bad++; $display("FAIL first_idle got=%b%b want=00", arvalid, rrdy); end
    total++; if (arprot !== 3'b001) begin bad++; $display("FAIL first_arprot got=%b want=001", arprot); end
  endtask

  task automatic test_mid_line();
    logic [31:0] a; bit st, ok;
    step(0, 0);
    total++; if (pxl_data !== 16'h0001) begin bad++; $display("FAIL mid_p0 got=%h want=0001", pxl_data); end
    step(1, 0);
    total++; if (pxl_data !== 16'h0002) begin bad++; $display("FAIL mid_p1 got=%h want=0002", pxl_data); end
    step(2, 0);
    total++; if (pxl_data !== 16'h0003) begin bad++; $display("FAIL mid_p2 got=%h want=0003", pxl_data); end
    step(3, 0);
    total++; if (pxl_data !== 16'h0004) begin bad++; $display("FAIL mid_p3 got=%h want=0004", pxl_data); end
    fetch(0, 64'h8888_7777_6666_5555, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h8) begin bad++; $display("FAIL mid_addr8 got=%h ok=%b want=8", a, ok); end
    step(4, 0);
    total++; if (pxl_data !== 16'h5555) begin bad++; $display("FAIL mid_p4 got=%h want=5555", pxl_data); end
    step(5, 0);
    total++; if (pxl_data !== 16'h6666) begin bad++; $display("FAIL mid_p5 got=%h want=6666", pxl_data); end
    @(negedge clk);
    total++; if (pxl_data !== 16'h6666) begin bad++; $display("FAIL mid_hold got=%h want=6666", pxl_data); end
    fetch(0, 64'h0000_0000_0000_0777, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h10) begin bad++; $display("FAIL mid_addr10 got=%h ok=%b want=10", a, ok); end
  endtask

  task automatic test_end_of_line();
    logic [31:0] a; bit st, ok;
    step(636, 0);
    total++; if (pxl_data !== 16'h0777) begin bad++; $display("FAIL eol_p636 got=%h want=0777", pxl_data); end
    fetch(0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h500) begin bad++; $display("FAIL eol_addr got=%h ok=%b want=500", a, ok); end
    step(700, 0);
    total++; if (pxl_data !== 16'h0) begin bad++; $display("FAIL eol_blank got=%h want=0", pxl_data); end
    step(636, 479);
    total++; if (pxl_data !== 16'hF00D) begin bad++; $display("FAIL eof_pxl got=%h want=f00d", pxl_data); end
    fetch(0, 64'h0123_4567_89AB_5A5A, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h0) begin bad++; $display("FAIL eof_wrap got=%h ok=%b want=0", a, ok); end
  endtask

  task automatic test_rd_err();
    logic [31:0] a; bit st, ok;
    step(0, 0);
    total++; if (pxl_data !== 16'h5A5A) begin bad++; $display("FAIL err_p0 got=%h want=5a5a", pxl_data); end
    fetch(3, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, a, st, ok);
    total++; if (!ok || a !== 32'h8) begin bad++; $display("FAIL err_addr got=%h ok=%b want=8", a, ok); end
    total++; if (!st) begin bad++; $display("FAIL err_ar_stable got=0 want=1"); end
    total++; if (rd_err !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b want=1", rd_err); end
    @(negedge clk);
    total++; if (rd_err !== 1'b0) begin bad++; $display("FAIL err_pulse_end got=%b want=0", rd_err); end
    step(4, 0);
    total++; if (pxl_data !== 16'h0) begin bad++; $display("FAIL err_pending got=%h want=0", pxl_data); end
    fetch(0, 64'h0000_0000_0000_ABCD, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h10 || rd_err !== 1'b0) begin bad++; $display("FAIL err_next got=%h ok=%b err=%b want=10/1/0", a, ok, rd_err); end
  endtask

  task automatic test_slow_slave();
    logic [31:0] a; bit st, ok; int ar_before;
    step(8, 0);
    total++; if (pxl_data !== 16'hABCD) begin bad++; $display("FAIL slow_p8 got=%h want=abcd", pxl_data); end
    serve_ar(0, a, st, ok);
    total++; if (!ok || a !== 32'h18) begin bad++; $display("FAIL slow_addr got=%h ok=%b want=18", a, ok); end
    ar_before = ar_hs;
    step(9, 0);
    step(10, 0);
    step(11, 0);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL slow_no_underrun got=%b want=0", underrun); end
    step(12, 0);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL slow_underrun got=%b want=1", underrun); end
    total++; if (pxl_data !== 16'hABCD) begin bad++; $display("FAIL slow_p12 got=%h want=abcd", pxl_data); end
    step(13, 0);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL slow_underrun_end got=%b want=0", underrun); end
    serve_r(64'h0000_0000_0000_1234, 2'b00, ok);
    total++; if (!ok) begin bad++; $display("FAIL slow_r_ok got=0 want=1"); end
    @(negedge clk);
    total++; if (arvalid !== 1'b0 || ar_hs !== ar_before) begin bad++; $display("FAIL slow_no_extra_ar got=%b/%0d want=0/%0d", arvalid, ar_hs, ar_before); end
    step(16, 0);
    total++; if (pxl_data !== 16'h1234) begin bad++; $display("FAIL slow_p16 got=%h want=1234", pxl_data); end
    fetch(0, 64'h0, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h28) begin bad++; $display("FAIL slow_next got=%h ok=%b want=28", a, ok); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a; bit st, ok;
    step(20, 0);
    total++; if (arvalid !== 1'b1 || araddr !== 32'h30) begin bad++; $display("FAIL rmid_req got=%b/%h want=1/30", arvalid, araddr); end
    pxl_ctr = 10'd700;
    rst_n = 1'b0;
    #1;
    total++; if (arvalid !== 1'b0 || rrdy !== 1'b0 || araddr !== 32'h0) begin bad++; $display("FAIL rmid_drop got=%b%b/%h want=00/0", arvalid, rrdy, araddr); end
    @(negedge clk);
    rst_n = 1'b1;
    fetch(0, 64'h0, 2'b00, a, st, ok);
    total++; if (!ok || a !== 32'h0) begin bad++; $display("FAIL rmid_restart got=%h ok=%b want=0", a, ok); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_mid_line();
    test_end_of_line();
    test_rd_err();
    test_slow_slave();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
